// File: rtl/cond_unit.sv
// Condition and pipeline-control unit: E/M control registers, NZCV flag register
// and condition-code evaluation for the execute stage.
module cond_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic       stall,
    input  logic       flush,
    input  logic [3:0] condD,
    input  logic [1:0] flagWD,
    input  logic       pcsD,
    input  logic       regWD,
    input  logic       memWD,
    input  logic       memtoRegD,
    input  logic       aluSrcD,
    input  logic [1:0] aluControlD,
    input  logic [3:0] aluFlags,
    output logic [1:0] aluControlE,
    output logic       aluSrcE,
    output logic       condExE,
    output logic       pcSrcE,
    output logic       regWriteM,
    output logic       memWriteM,
    output logic       memtoRegM,
    output logic       pcSrcM,
    output logic [3:0] flags
);

    logic       validE;
    logic [3:0] condE;
    logic [1:0] flagWE;
    logic       pcsE;
    logic       regWE;
    logic       memWE;
    logic       memtoRegE;
    logic       cond_pass;
    logic       n, z, c, v;

    assign {n, z, c, v} = flags;

    // Condition is evaluated against the architectural flags, not the live ALU result.
    always_comb begin
        cond_pass = 1'b0;
        unique case (condE)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = !z;
            4'b0010: cond_pass = c;
            4'b0011: cond_pass = !c;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = !n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = !v;
            4'b1000: cond_pass = c & !z;
            4'b1001: cond_pass = !c | z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = !z & (n == v);
            4'b1101: cond_pass = z | (n != v);
            4'b1110: cond_pass = 1'b1;
            4'b1111: cond_pass = 1'b0;
            default: cond_pass = 1'b0;
        endcase
    end

    assign condExE = validE & cond_pass;
    assign pcSrcE  = pcsE & condExE;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            validE      <= 1'b0;
            condE       <= 4'b0000;
            flagWE      <= 2'b00;
            pcsE        <= 1'b0;
            regWE       <= 1'b0;
            memWE       <= 1'b0;
            memtoRegE   <= 1'b0;
            aluSrcE     <= 1'b0;
            aluControlE <= 2'b00;
        end else if (!stall) begin
            validE      <= 1'b1;
            condE       <= condD;
            flagWE      <= flagWD;
            pcsE        <= pcsD;
            regWE       <= regWD;
            memWE       <= memWD;
            memtoRegE   <= memtoRegD;
            aluSrcE     <= aluSrcD;
            aluControlE <= aluControlD;
        end
    end

    // Flags and M stage see the current E instruction even when flush loads a bubble behind it.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags <= 4'b0000;
        end else if (!stall) begin
            if (flagWE[1] && condExE) flags[3:2] <= aluFlags[3:2];
            if (flagWE[0] && condExE) flags[1:0] <= aluFlags[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset || stall) begin
            regWriteM <= 1'b0;
            memWriteM <= 1'b0;
            memtoRegM <= 1'b0;
            pcSrcM    <= 1'b0;
        end else begin
            regWriteM <= regWE & condExE;
            memWriteM <= memWE & condExE;
            memtoRegM <= memtoRegE & validE;
            pcSrcM    <= pcSrcE;
        end
    end

endmodule

// File: tb/tb_cond_unit.sv
// Directed bench for cond_unit: reset, condition sweep, stall/flush interaction.
module tb_cond_unit;

    logic       clk = 1'b0;
    logic       reset, stall, flush;
    logic [3:0] condD;
    logic [1:0] flagWD;
    logic       pcsD, regWD, memWD, memtoRegD, aluSrcD;
    logic [1:0] aluControlD;
    logic [3:0] aluFlags;
    logic [1:0] aluControlE;
    logic       aluSrcE, condExE, pcSrcE;
    logic       regWriteM, memWriteM, memtoRegM, pcSrcM;
    logic [3:0] flags;

    int n_checks = 0;
    int n_fail   = 0;

    cond_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .condD(condD), .flagWD(flagWD), .pcsD(pcsD), .regWD(regWD),
        .memWD(memWD), .memtoRegD(memtoRegD), .aluSrcD(aluSrcD),
        .aluControlD(aluControlD), .aluFlags(aluFlags),
        .aluControlE(aluControlE), .aluSrcE(aluSrcE), .condExE(condExE),
        .pcSrcE(pcSrcE), .regWriteM(regWriteM), .memWriteM(memWriteM),
        .memtoRegM(memtoRegM), .pcSrcM(pcSrcM), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        condD = 4'hF; flagWD = 2'b00; pcsD = 1'b0; regWD = 1'b0; memWD = 1'b0;
        memtoRegD = 1'b0; aluSrcD = 1'b0; aluControlD = 2'b00;
    endtask

    // Loads an always-executing flag-setting instruction, then lets it retire.
    task automatic set_flags(input logic [3:0] f);
        nop(); condD = 4'hE; flagWD = 2'b11; aluFlags = f;
        tick();
        nop();
        tick();
    endtask

    function automatic logic cond_model(input logic [3:0] cc, input logic [3:0] f);
        logic fn, fz, fc, fv;
        {fn, fz, fc, fv} = f;
        case (cc)
            4'h0: return fz;
            4'h1: return !fz;
            4'h2: return fc;
            4'h3: return !fc;
            4'h4: return fn;
            4'h5: return !fn;
            4'h6: return fv;
            4'h7: return !fv;
            4'h8: return fc && !fz;
            4'h9: return !fc || fz;
            4'hA: return fn == fv;
            4'hB: return fn != fv;
            4'hC: return !fz && (fn == fv);
            4'hD: return fz || (fn != fv);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_flags"}, 8'(flags), 8'h0);
        check({tag, "_condEx"}, 8'(condExE), 8'h0);
        check({tag, "_pcSrcE"}, 8'(pcSrcE), 8'h0);
        check({tag, "_mstage"}, 8'({regWriteM, memWriteM, memtoRegM, pcSrcM}), 8'h0);
        check({tag, "_ectl"}, 8'({aluControlE, aluSrcE}), 8'h0);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b1; flush = 1'b1; aluFlags = 4'hF;
        nop(); regWD = 1'b1; condD = 4'hE;
        tick();
        tick();
        check_all_zero("reset");

        // Always-execute flag setter with register write
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        nop(); condD = 4'hE; regWD = 1'b1; flagWD = 2'b11; aluControlD = 2'b10; aluSrcD = 1'b1;
        aluFlags = 4'b0100;
        tick();
        check("load_condEx", 8'(condExE), 8'h1);
        check("load_aluCtl", 8'(aluControlE), 8'h2);
        check("load_aluSrc", 8'(aluSrcE), 8'h1);
        check("load_flags_pre", 8'(flags), 8'h0);
        nop();
        tick();
        check("load_flags", 8'(flags), 8'h4);
        check("load_regWM", 8'(regWriteM), 8'h1);
        check("nop_condEx", 8'(condExE), 8'h0);

        // EQ branch taken with Z=1, NE branch not taken
        nop(); condD = 4'h0; pcsD = 1'b1; regWD = 1'b1;
        tick();
        check("beq_pcSrcE", 8'(pcSrcE), 8'h1);
        nop();
        tick();
        check("beq_pcSrcM", 8'(pcSrcM), 8'h1);
        check("beq_regWM", 8'(regWriteM), 8'h1);
        nop(); condD = 4'h1; pcsD = 1'b1; regWD = 1'b1;
        tick();
        check("bne_pcSrcE", 8'(pcSrcE), 8'h0);
        check("bne_condEx", 8'(condExE), 8'h0);
        nop();
        tick();
        check("bne_regWM", 8'(regWriteM), 8'h0);
        check("bne_pcSrcM", 8'(pcSrcM), 8'h0);

        // memtoReg follows validity only, not the condition
        nop(); condD = 4'hF; memtoRegD = 1'b1; memWD = 1'b1;
        tick();
        nop();
        tick();
        check("mtr_memtoRegM", 8'(memtoRegM), 8'h1);
        check("mtr_memWM", 8'(memWriteM), 8'h0);

        // Full condition sweep
        for (int f = 0; f < 16; f++) begin
            nop(); condD = 4'hE; flagWD = 2'b11; aluFlags = 4'(f);
            tick();
            for (int cc = 0; cc < 16; cc++) begin
                nop(); condD = 4'(cc);
                tick();
                check($sformatf("sweep_c%0h_f%0h", cc, f), 8'(condExE),
                      8'(cond_model(4'(cc), 4'(f))));
            end
            check($sformatf("sweep_flags_f%0h", f), 8'(flags), 8'(f));
        end

        // Stall holds a flag-writing instruction; it updates N,Z exactly once on release
        set_flags(4'b0011);
        nop(); condD = 4'hE; flagWD = 2'b10; regWD = 1'b1; aluControlD = 2'b01;
        aluFlags = 4'b1000;
        tick();
        stall = 1'b1;
        nop();
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall%0d_flags", i), 8'(flags), 8'h3);
            check($sformatf("stall%0d_mstage", i),
                  8'({regWriteM, memWriteM, memtoRegM, pcSrcM}), 8'h0);
            check($sformatf("stall%0d_condEx", i), 8'(condExE), 8'h1);
            check($sformatf("stall%0d_aluCtl", i), 8'(aluControlE), 8'h1);
        end
        stall = 1'b0;
        tick();
        check("release_flags", 8'(flags), 8'hB);
        check("release_regWM", 8'(regWriteM), 8'h1);
        aluFlags = 4'b0101;
        tick();
        check("release_once", 8'(flags), 8'hB);

        // Flush behind a valid store-and-branch
        nop(); condD = 4'hE; memWD = 1'b1; pcsD = 1'b1;
        tick();
        check("flush_pre_pcSrcE", 8'(pcSrcE), 8'h1);
        flush = 1'b1;
        nop(); condD = 4'hE; regWD = 1'b1; aluControlD = 2'b11;
        tick();
        check("flush_memWM", 8'(memWriteM), 8'h1);
        check("flush_pcSrcM", 8'(pcSrcM), 8'h1);
        check("flush_condEx", 8'(condExE), 8'h0);
        check("flush_pcSrcE", 8'(pcSrcE), 8'h0);
        check("flush_aluCtl", 8'(aluControlE), 8'h0);
        flush = 1'b0;

        // Reset during stall with all flags set
        set_flags(4'hF);
        check("preRst_flags", 8'(flags), 8'hF);
        nop(); condD = 4'hE; regWD = 1'b1; aluSrcD = 1'b1; aluControlD = 2'b10;
        tick();
        stall = 1'b1; reset = 1'b1;
        tick();
        check_all_zero("rst_stall");

        reset = 1'b0; stall = 1'b0;
        nop(); condD = 4'hE; aluControlD = 2'b01; regWD = 1'b1;
        tick();
        check("postRst_condEx", 8'(condExE), 8'h1);
        check("postRst_aluCtl", 8'(aluControlE), 8'h1);
        nop();
        tick();
        check("postRst_regWM", 8'(regWriteM), 8'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cond_unit.md
COND_UNIT -- requirements
Module: cond_unit

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock, all state.
REQ-002 SHALL have: reset  input  1  synchronous, active-high; sampled on clk rising edge only.
REQ-003 SHALL have: stall  input  1  hold execute (E) register contents.
REQ-004 SHALL have: flush  input  1  load bubble into E register.
REQ-005 SHALL have: condD  input  4  instruction condition field [31:28], decode stage.
REQ-006 SHALL have: flagWD  input  2  decoder flag-write request; [1] = N,Z, [0] = C,V.
REQ-007 SHALL have: pcsD, regWD, memWD, memtoRegD, aluSrcD  input  1 each  decoder controls.
REQ-008 SHALL have: aluControlD  input  2  decoder ALU select.
REQ-009 SHALL have: aluFlags  input  4  {N,Z,C,V} from execute-stage ALU, combinational.
REQ-010 SHALL have: aluControlE  output  2; aluSrcE  output  1  registered E-stage controls.
REQ-011 SHALL have: condExE  output  1  E instruction valid and condition passes.
REQ-012 SHALL have: pcSrcE  output  1  branch/PC write taken in E; drives upstream flush.
REQ-013 SHALL have: regWriteM, memWriteM, memtoRegM, pcSrcM  output  1 each  memory-stage (M) controls.
REQ-014 SHALL have: flags  output  4  architectural {N,Z,C,V} register.

Function
REQ-015 SHALL hold an E register: validE, condE, flagWE, pcsE, regWE, memWE, memtoRegE, aluSrcE, aluControlE.
REQ-016 E register update priority per edge: reset > flush > stall > load; load captures all D inputs with validE=1.
REQ-017 Flush and reset SHALL clear every E field to 0 (bubble); stall SHALL hold every E field.
REQ-018 condExE SHALL be validE AND condition(condE, flags), using stored flags, never aluFlags.
REQ-019 Condition table: 0000 Z; 0001 !Z; 0010 C; 0011 !C; 0100 N; 0101 !N; 0110 V; 0111 !V; 1000 C&!Z; 1001 !C|Z; 1010 N==V; 1011 N!=V; 1100 !Z&(N==V); 1101 Z|(N!=V); 1110 1; 1111 0.
REQ-020 pcSrcE SHALL equal pcsE AND condExE, combinational, zero latency.
REQ-021 Flags N,Z SHALL load aluFlags[3:2] on edge when flagWE[1] AND condExE AND !stall; else hold.
REQ-022 Flags C,V SHALL load aluFlags[1:0] on edge when flagWE[0] AND condExE AND !stall; else hold.
REQ-023 stall SHALL prevent flag update so a held instruction updates flags exactly once.
REQ-024 flush in same cycle as a valid E instruction SHALL NOT suppress that instruction's flag update or M-stage capture (flush affects next E content only).
REQ-025 M register SHALL load each edge: regWriteM=regWE&condExE, memWriteM=memWE&condExE, memtoRegM=memtoRegE&validE, pcSrcM=pcSrcE.
REQ-026 When stall=1, M register SHALL load all zeros (bubble) instead of REQ-025 values.
REQ-027 Latency: D controls appear on E outputs 1 cycle after load; gated controls on M outputs 2 cycles after load.

Reset
REQ-028 On reset edge: E register bubble, M outputs 0, flags=0000, hence condExE=0, pcSrcE=0.
REQ-029 Reset mid-stall or mid-flush SHALL take precedence; first post-reset edge with stall=0, flush=0 loads D inputs normally.

Verification
REQ-030 Reset, then load cond=1110, regWD=1, flagWD=11, aluFlags=0100 -> condExE=1 next cycle; flags=0100 after following edge; regWriteM=1.
REQ-031 flags=0100, load cond=0000 pcsD=1 -> pcSrcE=1, pcSrcM=1 next edge; repeat with cond=0001 -> pcSrcE=0, regWriteM=0.
REQ-032 Sweep all 16 cond codes against all 16 flag values -> condExE matches REQ-019 table in every case, 1111 always 0.
REQ-033 Valid E instr with flagWE=10, aluFlags=1000, stall=1 for 3 cycles -> flags unchanged, M outputs 0, E held; on release flags N,Z=10 exactly once, C,V unchanged.
REQ-034 flush=1 with valid memW instr in E -> memWriteM=1 next edge, E becomes bubble (condExE=0, pcSrcE=0).
REQ-035 Assert reset during stall with flags=1111 -> flags=0000, all outputs 0 after edge.
